// File: rtl/mips_pkg.sv
// Shared types and constants for the unified memory arbiter.
package mips_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        DONE_I,
        DONE_D
    } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of D grants taken while fetch was waiting.
module arb_starve_counter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic f_clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge f_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sat = (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D) requesters.
module unified_mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              f_clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    arb_state_t state_q;
    logic [1:0] gnt;
    logic       starve_sat;
    logic       starve_inc;
    logic       starve_clr;

    // D wins unless fetch is waiting and has already lost STARVE_MAX times.
    always_comb begin
        gnt = GNT_NONE;
        if (state_q == IDLE) begin
            if (d_req && (!i_req || !starve_sat)) begin
                gnt = GNT_D;
            end else if (i_req) begin
                gnt = GNT_I;
            end
        end
    end

    assign starve_inc = (gnt == GNT_D) && i_req;
    assign starve_clr = (gnt == GNT_I);

    arb_starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .f_clk(f_clk),
        .rst  (rst),
        .inc  (starve_inc),
        .clr  (starve_clr),
        .sat  (starve_sat)
    );

    always_ff @(posedge f_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt == GNT_D) begin
                        state_q   <= GRANT_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        busy      <= 1'b1;
                    end else if (gnt == GNT_I) begin
                        state_q  <= GRANT_I;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= i_addr;
                        busy     <= 1'b1;
                    end
                end
                GRANT_I: begin
                    if (mem_ready) begin
                        state_q <= DONE_I;
                        mem_req <= 1'b0;
                        i_rdata <= mem_rdata;
                        i_ack   <= 1'b1;
                    end
                end
                GRANT_D: begin
                    if (mem_ready) begin
                        state_q <= DONE_D;
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        d_ack <= 1'b1;
                    end
                end
                DONE_I, DONE_D: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign stall_if  = i_req & ~i_ack;
    assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a latency-programmable memory model.
module tb_unified_mem_arbiter;

    logic        f_clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;

    logic [31:0] mem [16];
    int          lat;
    int          wcnt;
    logic        force_ready;
    int          n_checks;
    int          n_errors;

    unified_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(2)
    ) dut (
        .f_clk    (f_clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ack    (i_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .busy     (busy)
    );

    initial f_clk = 1'b0;
    always #5 f_clk = ~f_clk;

    // Memory answers after lat wait cycles of mem_req being high.
    assign mem_rdata = mem[mem_addr[5:2]];
    assign mem_ready = force_ready | (mem_req && (wcnt == lat));

    always @(posedge f_clk) begin
        wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        logic [1:0] grants [6];
        logic [1:0] exp_gnt [6];
        int         ng;
        logic       prev_req;
        logic       seen;

        n_checks    = 0;
        n_errors    = 0;
        wcnt        = 0;
        lat         = 0;
        force_ready = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = 32'hdead0000 | k;
        mem[1]  = 32'h200a0005;
        mem[2]  = 32'h22220008;
        mem[4]  = 32'h11110010;
        mem[5]  = 32'h55550014;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        rst     = 1'b1;

        @(negedge f_clk);
        @(negedge f_clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_i_ack", {31'd0, i_ack}, 32'd0);
        check("rst_d_ack", {31'd0, d_ack}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        @(negedge f_clk);

        // Single I read, L=1
        i_req = 1'b1; i_addr = 32'h4; lat = 1;
        #1;
        check("t1_stall_c0", {31'd0, stall_if}, 32'd1);
        check("t1_req_c0", {31'd0, mem_req}, 32'd0);
        @(negedge f_clk);
        check("t1_req_c1", {31'd0, mem_req}, 32'd1);
        check("t1_addr_c1", mem_addr, 32'h4);
        check("t1_we_c1", {31'd0, mem_we}, 32'd0);
        check("t1_stall_c1", {31'd0, stall_if}, 32'd1);
        @(negedge f_clk);
        check("t1_req_c2", {31'd0, mem_req}, 32'd1);
        check("t1_ack_c2", {31'd0, i_ack}, 32'd0);
        check("t1_stall_c2", {31'd0, stall_if}, 32'd1);
        @(negedge f_clk);
        check("t1_ack_c3", {31'd0, i_ack}, 32'd1);
        check("t1_rdata_c3", i_rdata, 32'h200a0005);
        check("t1_req_c3", {31'd0, mem_req}, 32'd0);
        check("t1_stall_c3", {31'd0, stall_if}, 32'd0);
        i_req = 1'b0;
        @(negedge f_clk);
        check("t1_ack_c4", {31'd0, i_ack}, 32'd0);
        check("t1_busy_c4", {31'd0, busy}, 32'd0);
        check("t1_rdata_hold", i_rdata, 32'h200a0005);

        // Simultaneous I and D load, L=0: D first
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; lat = 0;
        @(negedge f_clk);
        check("t2_req_c1", {31'd0, mem_req}, 32'd1);
        check("t2_addr_c1", mem_addr, 32'h10);
        check("t2_stall_if_c1", {31'd0, stall_if}, 32'd1);
        check("t2_stall_mem_c1", {31'd0, stall_mem}, 32'd1);
        @(negedge f_clk);
        check("t2_dack_c2", {31'd0, d_ack}, 32'd1);
        check("t2_drdata_c2", d_rdata, 32'h11110010);
        check("t2_stall_mem_c2", {31'd0, stall_mem}, 32'd0);
        d_req = 1'b0;
        @(negedge f_clk);
        check("t2_req_c3", {31'd0, mem_req}, 32'd0);
        check("t2_iack_c3", {31'd0, i_ack}, 32'd0);
        @(negedge f_clk);
        check("t2_req_c4", {31'd0, mem_req}, 32'd1);
        check("t2_addr_c4", mem_addr, 32'h8);
        @(negedge f_clk);
        check("t2_iack_c5", {31'd0, i_ack}, 32'd1);
        check("t2_irdata_c5", i_rdata, 32'h22220008);
        i_req = 1'b0;
        @(negedge f_clk);

        // Store, L=1
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h0000000c; lat = 1;
        @(negedge f_clk);
        check("t3_req_c1", {31'd0, mem_req}, 32'd1);
        check("t3_we_c1", {31'd0, mem_we}, 32'd1);
        check("t3_addr_c1", mem_addr, 32'h8);
        check("t3_wdata_c1", mem_wdata, 32'hc);
        @(negedge f_clk);
        check("t3_req_c2", {31'd0, mem_req}, 32'd1);
        check("t3_we_c2", {31'd0, mem_we}, 32'd1);
        check("t3_wdata_c2", mem_wdata, 32'hc);
        @(negedge f_clk);
        check("t3_dack_c3", {31'd0, d_ack}, 32'd1);
        check("t3_drdata_kept", d_rdata, 32'h11110010);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge f_clk);
        check("t3_dack_c4", {31'd0, d_ack}, 32'd0);

        // Starvation with STARVE_MAX=2: expect D, D, I, D, D, I
        exp_gnt = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        for (int k = 0; k < 6; k++) grants[k] = 2'b11;
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_addr = 32'h30; lat = 0;
        ng = 0; prev_req = 1'b0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge f_clk);
            if (mem_req && !prev_req && ng < 6) begin
                grants[ng] = (mem_addr == 32'h20) ? 2'b01 : 2'b10;
                ng++;
            end
            prev_req = mem_req;
            if (ng == 6 && i_ack) begin
                seen = 1'b1;
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        check("t4_done", {31'd0, seen}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t4_grant%0d", k), {30'd0, grants[k]}, {30'd0, exp_gnt[k]});
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge f_clk);
        @(negedge f_clk);

        // Reset while GRANT_D waits on memory
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14; lat = 5;
        @(negedge f_clk);
        check("t5_req_c1", {31'd0, mem_req}, 32'd1);
        check("t5_busy_c1", {31'd0, busy}, 32'd1);
        @(negedge f_clk);
        rst = 1'b1;
        #1;
        check("t5_rst_req", {31'd0, mem_req}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_dack", {31'd0, d_ack}, 32'd0);
        check("t5_rst_drdata", d_rdata, 32'd0);
        @(negedge f_clk);
        check("t5_rst_dack2", {31'd0, d_ack}, 32'd0);
        rst = 1'b0; lat = 1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge f_clk);
            if (d_ack) seen = 1'b1;
        end
        check("t5_reissue_ack", {31'd0, seen}, 32'd1);
        check("t5_reissue_rdata", d_rdata, 32'h55550014);
        d_req = 1'b0;
        @(negedge f_clk);

        // mem_ready with no requests is ignored
        force_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge f_clk);
            check($sformatf("t6_busy%0d", c), {31'd0, busy}, 32'd0);
            check($sformatf("t6_acks%0d", c), {30'd0, i_ack, d_ack}, 32'd0);
            check($sformatf("t6_req%0d", c), {31'd0, mem_req}, 32'd0);
        end
        force_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port backing memory between two pipeline requesters: instruction fetch (I port) and memory-stage load/store (D port).
- Sits between the fetch and memory stages and the memory model. It grants one access at a time and tracks outstanding transactions with an FSM.
- Produces stall signals so the pipeline freezes IF/ID or EX/MEM while an access is pending.
- D requests win by default. A bounded starvation counter guarantees fetch forward progress.

Parameters:
- ADDR_W, 32, byte-address width on all ports.
- DATA_W, 32, data word width.
- STARVE_MAX, 4, number of D grants allowed while I is pending before I is forced to win.

Ports:
- f_clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; level, held until i_ack.
- i_addr  in  ADDR_W  fetch byte address.
- i_rdata  out  DATA_W  fetched word; valid when i_ack=1, held afterwards.
- i_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid when d_ack=1 on a load, held afterwards.
- d_ack  out  1  one-cycle completion pulse for data.
- mem_req  out  1  backing-memory request, registered.
- mem_we  out  1  backing-memory write enable, registered.
- mem_addr  out  ADDR_W  registered address; word index is mem_addr[ADDR_W-1:2].
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ready.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- stall_if  out  1  i_req & ~i_ack (combinational).
- stall_mem  out  1  d_req & ~d_ack (combinational).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE.
  - mem_req, mem_we, i_ack, d_ack, busy = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - Starvation count = 0.
- Reset mid-transaction: the access is abandoned with no ack. The requester must re-issue after reset.
- States: IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D.
- Arbitration in IDLE only:
  - If d_req=1 and (i_req=0 or starve_cnt<STARVE_MAX): go to GRANT_D.
  - Else if i_req=1: go to GRANT_I.
  - Else: stay in IDLE.
- Starvation counter:
  - Increments on every GRANT_D entry taken while i_req=1; saturates at STARVE_MAX.
  - Clears on GRANT_I entry.
- Register loads on entering GRANT_x:
  - mem_addr, mem_we and mem_wdata load from the winning port.
  - For I, mem_we=0 and mem_wdata is unchanged.
  - mem_req goes to 1.
- GRANT_x: hold all mem_* outputs stable until mem_ready=1, then:
  - mem_req goes to 0.
  - If the access is a read, mem_rdata is captured into i_rdata or d_rdata.
  - FSM moves to DONE_x.
- Stores: d_rdata is unchanged and d_ack still pulses.
- DONE_x: the matching ack is 1 for exactly this cycle; FSM then returns to IDLE.
- Requester rule: the requester drops req or presents its next access on the edge where it samples ack=1. Request inputs are ignored outside IDLE.
- Latency: req seen at edge N, mem_req high from N+1, mem_ready at edge N+1+L (L≥0 wait cycles), ack high in cycle N+2+L.
  - Minimum request-to-ack is 2 cycles; back-to-back throughput is 1 access per L+3 cycles.
- Simultaneous i_req and d_req: D wins unless the starvation counter is saturated.
- Holding a request: the arbiter never drops a req that is held; the losing port simply waits in stall.
- mem_ready while mem_req=0 is ignored.
- Address bits [1:0] pass through unchanged; alignment is the memory's concern.

Decomposition:
- Shared package mips_pkg holds:
  - arb_state_t enum (IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D).
  - The grant encoding constants GNT_I and GNT_D.
  - The ADDR_W and DATA_W defaults.
- One sub-module, arb_starve_counter: saturating counter with inc, clr and sat outputs, parameterised by STARVE_MAX.

Test Plan:
- Single I read, L=1, i_addr=0x4, mem_rdata=0x200a0005 → mem_req high cycles 1–2, i_ack in cycle 3, i_rdata=0x200a0005, stall_if high cycles 0–2.
- Simultaneous i_req (addr 0x8) and d_req load (addr 0x10), L=0 → D served first with d_ack in cycle 2; I's mem_req starts cycle 4, i_ack in cycle 5.
- Store d_we=1, d_addr=0x8, d_wdata=0x0000000C → mem_we=1, mem_addr=0x8, mem_wdata=0xC while mem_req=1; d_ack pulses; d_rdata unchanged.
- Starvation, STARVE_MAX=2, d_req held continuously, i_req held → grant order D, D, I, D, D, I; counter clears after each I grant.
- Reset mid-transaction: assert rst while in GRANT_D and mem_ready=0 → mem_req=0 the same cycle, no d_ack, busy=0; after release the re-issued request completes normally.
- Idle-ready check: mem_ready held at 1 with no requests → FSM stays IDLE, no ack, busy=0.
